// File: rtl/btc_result_fifo.sv
// -----------------------------------------------------------------------------
// btc_result_fifo
//
// Collects results from a Bitcoin miner core. Every rising edge of the core's
// "done" level is one completed search. If the core reports a found nonce in
// that cycle, the {job_id, nonce} pair is queued in a small show-ahead FIFO
// for software to drain. Saturating counters track completed searches and
// successful searches. A sticky flag records dropped results. A registered
// interrupt is raised while results are pending or a drop has happened.
//
// Parameters
//   DEPTH        number of result entries (power of two, 2..16)
//   CW           width of the statistics counters
//
// Ports
//   clk          single clock; all state changes on its rising edge
//   arst         asynchronous active-low reset
//   done         miner core done level
//   nonce_found  miner core "nonce found" flag, meaningful while done is high
//   nonce        miner core nonce, meaningful while done is high
//   job_id       tag of the current job
//   pop          discard the head entry (ignored while empty)
//   clr          synchronous clear of FIFO, counters and sticky flag
//   irq_en       interrupt enable
//   head_nonce   nonce of the oldest entry (show-ahead, don't-care when empty)
//   head_job     job_id of the oldest entry
//   count        number of stored entries
//   empty, full  count == 0, count == DEPTH
//   overflow     sticky: a result was dropped because the FIFO was full
//   jobs_done    completed searches (saturating)
//   found_total  searches that found a nonce (saturating)
//   irq          registered interrupt
// -----------------------------------------------------------------------------
module btc_result_fifo #(
    parameter int DEPTH = 4,
    parameter int CW    = 16
) (
    input  logic                       clk,
    input  logic                       arst,
    input  logic                       done,
    input  logic                       nonce_found,
    input  logic [31:0]                nonce,
    input  logic [7:0]                 job_id,
    input  logic                       pop,
    input  logic                       clr,
    input  logic                       irq_en,
    output logic [31:0]                head_nonce,
    output logic [7:0]                 head_job,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       empty,
    output logic                       full,
    output logic                       overflow,
    output logic [CW-1:0]              jobs_done,
    output logic [CW-1:0]              found_total,
    output logic                       irq
);

    localparam int AW   = $clog2(DEPTH);
    localparam int CNTW = AW + 1;

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    logic            done_d_reg;
    logic [AW-1:0]   wr_ptr_reg,      wr_ptr_next;
    logic [AW-1:0]   rd_ptr_reg,      rd_ptr_next;
    logic [CNTW-1:0] count_reg,       count_next;
    logic            overflow_reg,    overflow_next;
    logic [CW-1:0]   jobs_done_reg,   jobs_done_next;
    logic [CW-1:0]   found_total_reg, found_total_next;
    logic            irq_reg,         irq_next;

    // Result storage: {job_id, nonce} per entry; contents only matter
    // between an accepted push and the pop that retires it, so no reset.
    logic [39:0]     mem [DEPTH];

    // -------------------------------------------------------------------------
    // Event qualification
    // -------------------------------------------------------------------------
    logic completion_evt;
    logic push_req;
    logic push_ok;
    logic pop_ok;
    logic empty_now;
    logic full_now;
    logic wr_en;

    assign empty_now      = (count_reg == '0);
    assign full_now       = (count_reg == CNTW'(DEPTH));

    // One event per rising edge of done, no matter how long done stays high.
    assign completion_evt = done & ~done_d_reg;
    assign push_req       = completion_evt & nonce_found;

    // A pop on an empty FIFO is a no-op; this also makes push+pop on empty
    // behave as a plain push.
    assign pop_ok         = pop & ~empty_now;

    // When full, a push only fits if the head is retired in the same cycle.
    assign push_ok        = push_req & (~full_now | pop_ok);

    // Storage is written only for pushes that are actually accepted.
    assign wr_en          = push_ok & ~clr;

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        wr_ptr_next      = wr_ptr_reg;
        rd_ptr_next      = rd_ptr_reg;
        count_next       = count_reg;
        overflow_next    = overflow_reg;
        jobs_done_next   = jobs_done_reg;
        found_total_next = found_total_reg;

        if (clr) begin
            wr_ptr_next      = '0;
            rd_ptr_next      = '0;
            count_next       = '0;
            overflow_next    = 1'b0;
            jobs_done_next   = '0;
            found_total_next = '0;
        end else begin
            // Pointers are AW bits wide, so +1 wraps modulo DEPTH.
            if (push_ok) begin
                wr_ptr_next = wr_ptr_reg + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr_next = rd_ptr_reg + AW'(1);
            end
            count_next = count_reg + CNTW'(push_ok) - CNTW'(pop_ok);

            // A found result that does not fit is dropped and remembered.
            if (push_req && !push_ok) begin
                overflow_next = 1'b1;
            end

            // Saturating statistics: hold at all-ones instead of wrapping.
            if (completion_evt && (jobs_done_reg != '1)) begin
                jobs_done_next = jobs_done_reg + CW'(1);
            end
            if (push_req && (found_total_reg != '1)) begin
                found_total_next = found_total_reg + CW'(1);
            end
        end

        // Interrupt follows the state the FIFO is about to enter, so it
        // changes on the same edge as count/overflow.
        irq_next = irq_en & ((count_next != '0) | overflow_next);
    end

    // -------------------------------------------------------------------------
    // Control and status registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            done_d_reg      <= 1'b0;
            wr_ptr_reg      <= '0;
            rd_ptr_reg      <= '0;
            count_reg       <= '0;
            overflow_reg    <= 1'b0;
            jobs_done_reg   <= '0;
            found_total_reg <= '0;
            irq_reg         <= 1'b0;
        end else begin
            // done_d keeps tracking done through clr, so a clear issued while
            // done is held high does not fabricate a new event afterwards.
            done_d_reg      <= done;
            wr_ptr_reg      <= wr_ptr_next;
            rd_ptr_reg      <= rd_ptr_next;
            count_reg       <= count_next;
            overflow_reg    <= overflow_next;
            jobs_done_reg   <= jobs_done_next;
            found_total_reg <= found_total_next;
            irq_reg         <= irq_next;
        end
    end

    // -------------------------------------------------------------------------
    // Storage array
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_reg] <= {job_id, nonce};
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    // Show-ahead read: head is a straight combinational read at rd_ptr.
    assign head_nonce  = mem[rd_ptr_reg][31:0];
    assign head_job    = mem[rd_ptr_reg][39:32];
    assign count       = count_reg;
    assign empty       = empty_now;
    assign full        = full_now;
    assign overflow    = overflow_reg;
    assign jobs_done   = jobs_done_reg;
    assign found_total = found_total_reg;
    assign irq         = irq_reg;

endmodule

// File: tb/tb_btc_result_fifo.sv
// -----------------------------------------------------------------------------
// tb_btc_result_fifo
//
// Drives directed scenarios and a randomized phase into btc_result_fifo.
// A queue-based reference model of the result FIFO and its counters is
// advanced on every rising edge and compared against the DUT 1 ns later.
// Directed scenarios add hand-computed literal expectations.
// -----------------------------------------------------------------------------
module tb_btc_result_fifo;

    localparam int DEPTH = 4;
    localparam int CW    = 8;
    localparam int CMAX  = (1 << CW) - 1;

    logic              clk = 1'b0;
    logic              arst;
    logic              done;
    logic              nonce_found;
    logic [31:0]       nonce;
    logic [7:0]        job_id;
    logic              pop;
    logic              clr;
    logic              irq_en;
    logic [31:0]       head_nonce;
    logic [7:0]        head_job;
    logic [2:0]        count;
    logic              empty;
    logic              full;
    logic              overflow;
    logic [CW-1:0]     jobs_done;
    logic [CW-1:0]     found_total;
    logic              irq;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    btc_result_fifo #(.DEPTH(DEPTH), .CW(CW)) dut (
        .clk         (clk),
        .arst        (arst),
        .done        (done),
        .nonce_found (nonce_found),
        .nonce       (nonce),
        .job_id      (job_id),
        .pop         (pop),
        .clr         (clr),
        .irq_en      (irq_en),
        .head_nonce  (head_nonce),
        .head_job    (head_job),
        .count       (count),
        .empty       (empty),
        .full        (full),
        .overflow    (overflow),
        .jobs_done   (jobs_done),
        .found_total (found_total),
        .irq         (irq)
    );

    // ---------------- reference model ----------------
    logic [39:0] mq[$];
    bit          m_done_d;
    int          m_jobs;
    int          m_found;
    bit          m_ovf;
    bit          m_irq;

    task automatic model_reset();
        mq.delete();
        m_done_d = 0;
        m_jobs   = 0;
        m_found  = 0;
        m_ovf    = 0;
        m_irq    = 0;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model advance on the rising edge, then compare once outputs settled.
    always @(posedge clk) begin
        bit evt, was_full, pop_ok;
        if (!arst) begin
            model_reset();
        end else begin
            evt      = done && !m_done_d;
            m_done_d = done;
            if (clr) begin
                mq.delete();
                m_jobs  = 0;
                m_found = 0;
                m_ovf   = 0;
            end else begin
                was_full = (mq.size() == DEPTH);
                pop_ok   = pop && (mq.size() > 0);
                if (evt && m_jobs < CMAX) m_jobs++;
                if (pop_ok) void'(mq.pop_front());
                if (evt && nonce_found) begin
                    if (m_found < CMAX) m_found++;
                    if (!was_full || pop_ok) mq.push_back({job_id, nonce});
                    else m_ovf = 1;
                end
            end
            m_irq = irq_en && ((mq.size() > 0) || m_ovf);
        end
        #1;
        chk("count",       64'(count),       64'(mq.size()));
        chk("empty",       64'(empty),       64'(mq.size() == 0));
        chk("full",        64'(full),        64'(mq.size() == DEPTH));
        chk("overflow",    64'(overflow),    64'(m_ovf));
        chk("jobs_done",   64'(jobs_done),   64'(m_jobs));
        chk("found_total", 64'(found_total), 64'(m_found));
        chk("irq",         64'(irq),         64'(m_irq));
        if (mq.size() > 0) begin
            chk("head_nonce", 64'(head_nonce), 64'(mq[0][31:0]));
            chk("head_job",   64'(head_job),   64'(mq[0][39:32]));
        end
    end

    // ---------------- stimulus helpers ----------------
    // One completion event (done high for one cycle, then low).
    task automatic ev(input bit f, input logic [31:0] n, input logic [7:0] j, input bit p);
        @(negedge clk);
        done = 1; nonce_found = f; nonce = n; job_id = j; pop = p;
        @(negedge clk);
        done = 0; nonce_found = 0; pop = 0;
    endtask

    task automatic do_pop();
        @(negedge clk); pop = 1;
        @(negedge clk); pop = 0;
    endtask

    task automatic do_clr();
        @(negedge clk); clr = 1;
        @(negedge clk); clr = 0;
    endtask

    initial begin
        arst = 0; done = 0; nonce_found = 0; nonce = 0; job_id = 0;
        pop = 0; clr = 0; irq_en = 0;
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_empty", 64'(empty), 64'd1);
        chk("rst_full",  64'(full),  64'd0);
        chk("rst_irq",   64'(irq),   64'd0);
        arst = 1;
        $display("reset released");

        // Long done pulse gives exactly one push.
        @(negedge clk);
        done = 1; nonce_found = 1; nonce = 32'h1234ABCD; job_id = 8'h05;
        repeat (10) @(negedge clk);
        done = 0; nonce_found = 0;
        @(negedge clk);
        chk("long_head_nonce", 64'(head_nonce), 64'h1234ABCD);
        chk("long_head_job",   64'(head_job),   64'h05);
        chk("long_count",      64'(count),      64'd1);
        chk("long_jobs",       64'(jobs_done),  64'd1);
        chk("long_found",      64'(found_total),64'd1);
        $display("long done pulse: count=%0d jobs=%0d", count, jobs_done);
        do_clr();

        // Events without a nonce.
        irq_en = 1;
        for (int i = 0; i < 3; i++) ev(0, 32'hDEAD0000 + i, 8'h01, 0);
        chk("nf_jobs",  64'(jobs_done),   64'd3);
        chk("nf_found", 64'(found_total), 64'd0);
        chk("nf_empty", 64'(empty),       64'd1);
        chk("nf_irq",   64'(irq),         64'd0);
        $display("three empty events: jobs=%0d", jobs_done);
        irq_en = 0;
        do_clr();

        // Overflow: five found events into a 4-deep FIFO.
        for (int i = 1; i <= 5; i++) ev(1, 32'(i), 8'h10, 0);
        chk("ovf_count", 64'(count),       64'd4);
        chk("ovf_full",  64'(full),        64'd1);
        chk("ovf_flag",  64'(overflow),    64'd1);
        chk("ovf_found", 64'(found_total), 64'd5);
        for (int i = 1; i <= 4; i++) begin
            chk("ovf_order", 64'(head_nonce), 64'(i));
            do_pop();
        end
        chk("ovf_sticky", 64'(overflow), 64'd1);
        do_clr();
        chk("ovf_clr", 64'(overflow), 64'd0);
        $display("overflow scenario done");

        // Push and pop together while full.
        for (int i = 10; i <= 13; i++) ev(1, 32'(i), 8'h20, 0);
        ev(1, 32'd14, 8'h21, 1);
        chk("fpp_count", 64'(count),    64'd4);
        chk("fpp_ovf",   64'(overflow), 64'd0);
        for (int i = 11; i <= 14; i++) begin
            chk("fpp_order", 64'(head_nonce), 64'(i));
            do_pop();
        end
        chk("fpp_last_job_empty", 64'(empty), 64'd1);
        $display("full push+pop scenario done");

        // Interrupt and clear with done held high.
        irq_en = 1;
        ev(1, 32'hCAFE0001, 8'h33, 0);
        chk("irq_count", 64'(count), 64'd1);
        chk("irq_set",   64'(irq),   64'd1);
        do_pop();
        chk("irq_empty", 64'(empty), 64'd1);
        chk("irq_drop",  64'(irq),   64'd0);
        ev(1, 32'hCAFE0002, 8'h34, 0);
        @(negedge clk);
        done = 1; nonce_found = 1; nonce = 32'hCAFE0003; clr = 1;
        @(negedge clk);
        clr = 0;
        repeat (3) @(negedge clk);
        chk("clrh_count", 64'(count),       64'd0);
        chk("clrh_jobs",  64'(jobs_done),   64'd0);
        chk("clrh_found", 64'(found_total), 64'd0);
        chk("clrh_irq",   64'(irq),         64'd0);
        done = 0; nonce_found = 0;
        $display("irq / clr-held scenario done");

        // Asynchronous reset mid-operation, done high at release.
        for (int i = 0; i < 3; i++) ev(1, 32'h5000 + i, 8'h40, 0);
        @(negedge clk);
        #2 arst = 0;
        #1;
        chk("arst_empty", 64'(empty),       64'd1);
        chk("arst_count", 64'(count),       64'd0);
        chk("arst_jobs",  64'(jobs_done),   64'd0);
        chk("arst_found", 64'(found_total), 64'd0);
        chk("arst_irq",   64'(irq),         64'd0);
        model_reset();
        @(negedge clk);
        done = 1; nonce_found = 1; nonce = 32'h77; job_id = 8'h41;
        arst = 1;
        @(negedge clk);
        done = 0; nonce_found = 0;
        chk("rel_jobs",  64'(jobs_done),  64'd1);
        chk("rel_head",  64'(head_nonce), 64'h77);
        $display("async reset scenario done");
        do_clr();

        // Saturation of both counters.
        irq_en = 0;
        for (int i = 0; i < CMAX + 5; i++) ev(1, 32'(i), 8'(i), 1);
        chk("sat_jobs",  64'(jobs_done),   64'(CMAX));
        chk("sat_found", 64'(found_total), 64'(CMAX));
        $display("saturation: jobs=%0d found=%0d", jobs_done, found_total);
        do_clr();

        // Randomized phase.
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            done        = ($urandom_range(0, 2) == 0);
            nonce_found = ($urandom_range(0, 1) == 1);
            nonce       = $urandom;
            job_id      = 8'($urandom_range(0, 255));
            pop         = ($urandom_range(0, 3) == 0);
            clr         = ($urandom_range(0, 80) == 0);
            irq_en      = ($urandom_range(0, 9) != 0);
        end
        @(negedge clk);
        done = 0; pop = 0; clr = 0;
        repeat (2) @(negedge clk);
        $display("random phase done");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
